// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the timer scheduler: FSM state encoding and
// the round-robin selection function used at grant time.
package timer_sched_pkg;

   // Upper bound on requesters handled by the selection function; the
   // requester index is carried in IDX_W bits throughout the scheduler.
   localparam int MAX_REQ = 32;
   localparam int IDX_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // Returns the first set request at or after ptr, wrapping at num_req.
   // ptr is always below num_req, so one conditional subtraction is enough
   // to wrap the candidate index.
   function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int                 num_req);
      rr_pick_t pick;
      int       cand;
      pick.valid = 1'b0;
      pick.idx   = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < num_req) begin
            cand = int'(ptr) + k;
            if (cand >= num_req) begin
               cand = cand - num_req;
            end
            if (!pick.valid && req[cand]) begin
               pick.valid = 1'b1;
               pick.idx   = cand[IDX_W-1:0];
            end
         end
      end
      return pick;
   endfunction

   // Next round-robin pointer after servicing idx.
   function automatic logic [IDX_W-1:0] rr_advance(input logic [IDX_W-1:0] idx,
                                                   input int               num_req);
      logic [IDX_W-1:0] nxt;
      if (int'(idx) >= num_req - 1) begin
         nxt = '0;
      end else begin
         nxt = idx + IDX_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sched_timer_core.sv
// Shared interval counter. Cleared by the scheduler while idle, advanced
// while a requester is being timed, and flags when the loaded value is hit.
module sched_timer_core
   import timer_sched_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [N-1:0] final_value,
   output logic [N-1:0] count,
   output logic         at_final
);

   // Counter register: clear has priority over enable.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + N'(1);
      end
   end

   assign at_final = (count == final_value);

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one interval counter among NUM_REQ
// requesters. A granted requester waits (value + 1) cycles in RUN, then
// receives a one-cycle done pulse while its grant is still held.
module timer_scheduler
   import timer_sched_pkg::*;
#(
   parameter int N       = 16,
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*N-1:0] req_value,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   done,
   output logic                 busy,
   output logic [N-1:0]         count
);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [N-1:0]         v_q, v_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 clear;
   logic                 enable;
   logic                 at_final;
   logic [MAX_REQ-1:0]   req_ext;
   rr_pick_t             pick;

   // Zero-extended request vector lets the selection function and the
   // abort check index with the full IDX_W-bit requester index.
   assign req_ext = MAX_REQ'(req);
   assign pick    = rr_next(req_ext, rr_ptr_q, NUM_REQ);

   sched_timer_core #(
      .N (N)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .enable      (enable),
      .final_value (v_q),
      .count       (count),
      .at_final    (at_final)
   );

   // Next-state, counter control and registered-output next values.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gidx_d   = gidx_q;
      v_d      = v_q;
      grant_d  = grant_q;
      done_d   = '0;
      clear    = 1'b0;
      enable   = 1'b0;
      case (state_q)
         IDLE: begin
            clear = 1'b1;
            if (pick.valid) begin
               state_d = RUN;
               gidx_d  = pick.idx;
               v_d     = req_value[int'(pick.idx)*N +: N];
               grant_d = NUM_REQ'(1) << pick.idx;
            end
         end
         RUN: begin
            if (!req_ext[gidx_q]) begin
               // Requester withdrew: release without done, still move on.
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = rr_advance(gidx_q, NUM_REQ);
            end else if (at_final) begin
               // Counter holds at V so it can never pass it or wrap.
               state_d = DONE;
               done_d  = grant_q;
            end else begin
               enable = 1'b1;
            end
         end
         DONE: begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_advance(gidx_q, NUM_REQ);
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, pointer, latched value and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gidx_q   <= '0;
         v_q      <= '0;
         grant_q  <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gidx_q   <= gidx_d;
         v_q      <= v_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler: stimulus pushes the expected grant
// window of every service into a queue; a negedge monitor pops and checks
// grant rise, done pulse, grant fall and the peak counter value.
module tb_timer_scheduler;

   localparam int N       = 16;
   localparam int NUM_REQ = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*N-1:0] req_value;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   done;
   logic                 busy;
   logic [N-1:0]         count;

   typedef struct {
      int idx;
      int gcyc;    // cycle grant first visible
      int dcyc;    // done cycle, or grant-fall cycle when abort is set
      int maxc;    // highest count seen while granted
      bit abort;   // no done expected
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   timer_scheduler #(
      .N       (N),
      .NUM_REQ (NUM_REQ)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_value (req_value),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Cycle index; read by stimulus #1 after the edge and by the monitor.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
      tests++;
      if (act !== req_v) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req_v, cyc);
      end
   endtask

   task automatic push(input int idx, input int gcyc, input int dcyc, input int maxc, input bit abort);
      exp_t e;
      e.idx = idx; e.gcyc = gcyc; e.dcyc = dcyc; e.maxc = maxc; e.abort = abort;
      exp_q.push_back(e);
   endtask

   // Advance to #1 after the edge that starts cycle c.
   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_val(input int i, input logic [N-1:0] v);
      req_value[i*N +: N] = v;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_done"},  done,  0);
      chk({tag, "_busy"},  busy,  0);
      chk({tag, "_count"}, count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor
   exp_t               cur;
   bit                 have_cur   = 1'b0;
   int                 maxc       = 0;
   logic [NUM_REQ-1:0] prev_grant = '0;

   always @(negedge clk) begin
      if (grant != 0 && prev_grant == 0) begin
         if (exp_q.size() == 0) begin
            chk("grant_unexpected", grant, 0);
         end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            maxc     = 0;
            chk("grant_idx",  grant, NUM_REQ'(1) << cur.idx);
            chk("grant_cyc",  cyc,   cur.gcyc);
            chk("busy_rise",  busy,  1);
            chk("count_zero", count, 0);
         end
      end else if (grant != 0 && prev_grant != 0 && grant != prev_grant) begin
         chk("grant_stable", grant, prev_grant);
      end
      if (grant != 0 && int'(count) > maxc) maxc = int'(count);
      if (done != 0) begin
         if (!have_cur || cur.abort) begin
            chk("done_unexpected", done, 0);
         end else begin
            chk("done_idx",  done,  NUM_REQ'(1) << cur.idx);
            chk("done_cyc",  cyc,   cur.dcyc);
            chk("done_held", grant, done);
         end
      end
      if (grant == 0 && prev_grant != 0 && have_cur) begin
         chk("fall_cyc",  cyc,  cur.abort ? cur.dcyc : cur.dcyc + 1);
         chk("busy_fall", busy, 0);
         chk("max_count", maxc, cur.maxc);
         have_cur = 1'b0;
      end
      prev_grant = grant;
   end

   int t;

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_value = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_done",  done,  0);
      chk("rst_busy",  busy,  0);
      chk("rst_count", count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      at_cycle(cyc + 1);

      // Single requester, V = 256.
      t = cyc;
      set_val(0, 16'd256);
      req = 4'b0001;
      push(0, t + 1, t + 258, 256, 1'b0);
      at_cycle(t + 259);
      req = 4'b0000;
      at_cycle(t + 261);
      do_reset("rst2");

      // All four at once, values 3/5/0/7, each drops after its done.
      t = cyc;
      set_val(0, 16'd3); set_val(1, 16'd5); set_val(2, 16'd0); set_val(3, 16'd7);
      req = 4'b1111;
      push(0, t + 1,  t + 5,  3, 1'b0);
      push(1, t + 7,  t + 13, 5, 1'b0);
      push(2, t + 15, t + 16, 0, 1'b0);
      push(3, t + 18, t + 26, 7, 1'b0);
      at_cycle(t + 6);  req[0] = 1'b0;
      at_cycle(t + 14); req[1] = 1'b0;
      at_cycle(t + 17); req[2] = 1'b0;
      at_cycle(t + 27); req[3] = 1'b0;
      at_cycle(t + 29);
      do_reset("rst3");

      // Fairness: req[1] held, req[2] arrives once while 1 is running.
      t = cyc;
      set_val(1, 16'd2);
      req = 4'b0010;
      push(1, t + 1, t + 4, 2, 1'b0);
      at_cycle(t + 2);
      set_val(2, 16'd4);
      req[2] = 1'b1;
      push(2, t + 6,  t + 11, 4, 1'b0);
      push(1, t + 13, t + 16, 2, 1'b0);
      at_cycle(t + 12); req[2] = 1'b0;
      at_cycle(t + 17); req[1] = 1'b0;
      at_cycle(t + 19);

      // Abort: req[3] V=100 dropped at count 40; 0 and 2 waiting.
      t = cyc;
      set_val(3, 16'd100);
      req[3] = 1'b1;
      push(3, t + 1, t + 42, 40, 1'b1);
      at_cycle(t + 10);
      set_val(0, 16'd1); set_val(2, 16'd2);
      req[0] = 1'b1; req[2] = 1'b1;
      push(0, t + 43, t + 45, 1, 1'b0);
      push(2, t + 47, t + 50, 2, 1'b0);
      at_cycle(t + 41); req[3] = 1'b0;
      at_cycle(t + 46); req[0] = 1'b0;
      at_cycle(t + 51); req[2] = 1'b0;
      at_cycle(t + 53);

      // Reset mid-RUN at count 10, then re-request 1 and 3.
      t = cyc;
      set_val(1, 16'd50);
      req[1] = 1'b1;
      push(1, t + 1, t + 12, 10, 1'b1);
      at_cycle(t + 11);
      reset = 1'b1;
      at_cycle(t + 12);
      reset = 1'b0;
      set_val(1, 16'd5); set_val(3, 16'd0);
      req[3] = 1'b1;
      push(1, t + 13, t + 19, 5, 1'b0);
      push(3, t + 21, t + 22, 0, 1'b0);
      @(negedge clk);
      chk("midrst_grant", grant, 0);
      chk("midrst_done",  done,  0);
      chk("midrst_busy",  busy,  0);
      chk("midrst_count", count, 0);
      at_cycle(t + 20); req[1] = 1'b0;
      at_cycle(t + 23); req[3] = 1'b0;
      at_cycle(t + 25);

      // Boundaries: V = 0 then V = 65535.
      t = cyc;
      set_val(0, 16'd0);
      req[0] = 1'b1;
      push(0, t + 1, t + 2, 0, 1'b0);
      at_cycle(t + 3);
      req[0] = 1'b0;
      set_val(2, 16'hFFFF);
      req[2] = 1'b1;
      push(2, t + 4, t + 65540, 65535, 1'b0);
      at_cycle(t + 65541); req[2] = 1'b0;
      at_cycle(t + 65544);

      chk("queue_drained", exp_q.size(), 0);
      chk("none_active",   have_cur,     0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
